fp_mul_issue: RTL and testbench
===============================

# fp_mul_issue

Issue and result-collection stage wrapped around the 4-stage floating-point multiplier. It accepts operand pairs on a valid/ready interface and drives the multiplier's `start`/`op_a`/`op_b` pins. It captures each `done`/`res` into a result FIFO and presents results in issue order on a valid/ready output. The multiplier cannot stall and finishes special operands (NaN/Inf) in 1 cycle instead of 4, so this block owns the flow control: credit-based issue, and hazard blocking on special operands.

## Interface
- `DATA_W`, 32, float width
- `EXP_W`, 8, exponent width; an operand is "special" when its exponent field `[DATA_W-2 -: EXP_W]` is all ones
- `DEPTH`, 8, result FIFO entries; power of two, ≥2; full throughput requires ≥5
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: synchronous, active-high
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: block accepts pair this cycle (combinational)
- `in_a`, `in_b` in DATA_W: operands
- `mul_start` out 1: to multiplier `start`
- `mul_op_a`, `mul_op_b` out DATA_W: to multiplier `op_a`/`op_b`
- `mul_done` in 1: from multiplier `done`
- `mul_res` in DATA_W: from multiplier `res`
- `out_valid` out 1: FIFO non-empty
- `out_ready` in 1: consumer pops
- `out_res` out DATA_W: FIFO head
- `overflow_err` out 1: sticky; `mul_done` arrived while FIFO full
- `inflight` out $clog2(DEPTH)+1: ops issued, not yet done

## Operation
- `fire = in_valid & in_ready`; `mul_start = fire`; `mul_op_a/b = fire ? in_a/in_b : 0`. Zero operands when idle are mandatory: the multiplier's special path decodes op pins every cycle, and a NaN/Inf there while idle would corrupt its output.
- `pop = out_valid & out_ready`; `push = mul_done`.
- Credit: `in_ready` requires `count + inflight - pop < DEPTH`. A `mul_done` moves an entry from inflight to count, so the total is unchanged.
- Special hazard: if `in_a` or `in_b` is special, `in_ready` additionally requires `inflight == 0`. This keeps results in order and prevents a 1-cycle special `done` from colliding with a normal `done`. Normal pairs issued after a special pair need no extra check.
- `in_ready = 0` while `rst` is high.
- `inflight` update: `+fire - mul_done`. Both in the same cycle leaves it unchanged.
- FIFO: write/read pointers of $clog2(DEPTH) bits wrap modulo DEPTH, plus a `count` of $clog2(DEPTH)+1 bits. Show-ahead: `out_res` = mem[rd_ptr]. No bypass: a push into an empty FIFO becomes visible the next cycle. Push and pop in the same cycle are both performed.
- `push` while `count == DEPTH` and no `pop`: the entry is dropped and `overflow_err` sets until `rst`. Unreachable in correct use; it is an assertion target.
- `mul_done` with `inflight == 0`: the result is still pushed, `inflight` saturates at 0, and `overflow_err` sets.

## Timing
- Reset values: `out_valid` 0, `overflow_err` 0, `inflight` 0, `count` 0, pointers 0, `mul_start` 0, `mul_op_a/b` 0, `in_ready` 0.
- Normal pair accepted in cycle t: `mul_done` in t+4, `out_valid` in t+5 (FIFO was empty).
- Special pair accepted in cycle t: `mul_done` in t+1, `out_valid` in t+2.
- Throughput: 1 pair/cycle sustained with `out_ready` held high and DEPTH ≥ 5.
- Reset asserted mid-operation: block state clears on the next edge. The multiplier shares `rst`, so no stale `mul_done` follows.
- Combinational paths: `in_valid`/`in_a`/`in_b`/`out_ready` → `in_ready`, `mul_start`, `mul_op_*`.

## Test plan
- Single op: `in_a=0x40000000` (2.0), `in_b=0x40400000` (3.0) at t -> `mul_start` 1 in t only; `out_valid` at t+5 with `out_res=0x40C00000`; `inflight` reads 1 from t+1 to t+4.
- Streaming: 16 pairs back-to-back, `out_ready=1` -> `in_ready` never drops; 16 results in order; `overflow_err` stays 0.
- Backpressure: `out_ready=0` with continuous `in_valid` -> exactly 8 pairs accepted, then `in_ready=0`. Raise `out_ready` -> one more pair is accepted in the same cycle as each pop, and order is preserved.
- Special hazard: normal pair at t, then `in_a=0x7FC00000` (NaN) presented from t+1 -> `in_ready=0` through t+4; NaN accepted at t+5. `out_res` order: normal product, then `0x7FC00000`.
- Idle op zeroing: `in_valid=0` with `in_a=0x7F800000` -> `mul_op_a=0` and `mul_start=0`, and a concurrent in-flight normal result is delivered intact.
- Reset mid-flight: `rst` asserted 2 cycles after issuing 3 ops -> all outputs return to reset values; no `out_valid` afterwards.

Source files
------------

// File: rtl/fp_mul_issue.sv
// Issue and result-collection stage around a 4-stage FP multiplier: credit-based
// issue, special-operand hazard blocking, and an in-order show-ahead result FIFO.
module fp_mul_issue #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  output logic                       mul_start,
  output logic [DATA_W-1:0]          mul_op_a,
  output logic [DATA_W-1:0]          mul_op_b,
  input  logic                       mul_done,
  input  logic [DATA_W-1:0]          mul_res,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_res,
  output logic                       overflow_err,
  output logic [$clog2(DEPTH):0]     inflight
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = PTR_W + 2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              special_a;
  logic              special_b;
  logic              special;
  logic              pop;
  logic              push;
  logic              full;
  logic              drop;
  logic              do_write;
  logic              orphan;
  logic              fire;
  logic              credit_ok;
  logic [SUM_W-1:0]  committed;

  assign special_a = &in_a[DATA_W-2 -: EXP_W];
  assign special_b = &in_b[DATA_W-2 -: EXP_W];
  assign special   = special_a | special_b;

  assign out_valid = (count != '0);
  assign out_res   = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = mul_done;
  assign full      = (count == CNT_W'(DEPTH));
  assign drop      = push & full & ~pop;
  assign do_write  = push & ~drop;
  assign orphan    = mul_done & (inflight == '0);

  // Every issued op owns a FIFO slot from issue until it is popped, so the
  // multiplier (which cannot stall) can never push into a full FIFO.
  assign committed = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop);
  assign credit_ok = (committed < SUM_W'(DEPTH));

  // Specials finish in 1 cycle; waiting for an empty pipe keeps order and
  // avoids two dones landing in the same cycle.
  assign in_ready  = ~rst & credit_ok & (~special | (inflight == '0));
  assign fire      = in_valid & in_ready;

  // The multiplier decodes its op pins every cycle, so idle pins must be zero.
  assign mul_start = fire;
  assign mul_op_a  = fire ? in_a : '0;
  assign mul_op_b  = fire ? in_b : '0;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= mul_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      inflight     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count + CNT_W'(do_write) - CNT_W'(pop);
      inflight <= inflight + CNT_W'(fire) - CNT_W'(mul_done & ~orphan);
      if (drop || orphan) begin
        overflow_err <= 1'b1;
      end
    end
  end

  a_no_drop: assert property (@(posedge clk) disable iff (rst) !drop);

endmodule

// File: tb/tb_fp_mul_issue.sv
// Directed bench for fp_mul_issue with a behavioural 4-stage multiplier fixture
// whose special path decodes the op pins every cycle.
module tb_fp_mul_issue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              mul_start;
  logic [DATA_W-1:0] mul_op_a;
  logic [DATA_W-1:0] mul_op_b;
  logic              mul_done;
  logic [DATA_W-1:0] mul_res;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_res;
  logic              overflow_err;
  logic [3:0]        inflight;

  int checks;
  int failures;
  logic [31:0] received[$];
  logic [31:0] expected[$];

  fp_mul_issue #(.DATA_W(DATA_W), .EXP_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_done(mul_done), .mul_res(mul_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .overflow_err(overflow_err), .inflight(inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic is_special(input logic [31:0] v);
    return &v[30:23];
  endfunction

  // Exact products for the operand classes used here (x*1.0, x*2.0, NaN).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (is_special(a) || is_special(b)) return 32'h7FC0_0000;
    if (a == 32'h3F80_0000) return b;
    if (b == 32'h3F80_0000) return a;
    if (a == 32'h4000_0000) return b + 32'h0080_0000;
    if (b == 32'h4000_0000) return a + 32'h0080_0000;
    return 32'h0;
  endfunction

  logic [3:0]  pv;
  logic [31:0] pr [4];
  logic        sp_v;
  logic        sp_hit;
  logic        op_special;

  assign op_special = is_special(mul_op_a) | is_special(mul_op_b);
  assign mul_done   = pv[3] | sp_v;
  assign mul_res    = sp_hit ? 32'h7FC0_0000 : pr[3];

  always @(posedge clk) begin
    if (rst) begin
      pv     <= '0;
      sp_v   <= 1'b0;
      sp_hit <= 1'b0;
    end else begin
      pv     <= {pv[2:0], mul_start & ~op_special};
      pr[0]  <= fmul(mul_op_a, mul_op_b);
      pr[1]  <= pr[0];
      pr[2]  <= pr[1];
      pr[3]  <= pr[2];
      sp_v   <= mul_start & op_special;
      sp_hit <= op_special;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) received.push_back(out_res);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4000_0000; out_ready = 1'b0;
    step();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if (mul_start !== 1'b0 || mul_op_a !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_mul_pins got start=%b op_a=%h want 0/0", mul_start, mul_op_a);
    end
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || overflow_err !== 1'b0 || inflight !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got ov=%b err=%b infl=%0d want 0/0/0", out_valid, overflow_err, inflight);
    end
    step();
  endtask

  task automatic test_single();
    received.delete();
    in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4040_0000;
    #1;
    checks++;
    if (mul_start !== 1'b1 || mul_op_a !== 32'h4000_0000 || mul_op_b !== 32'h4040_0000) begin
      failures++;
      $display("[TB] FAIL single_issue got start=%b a=%h b=%h want 1/40000000/40400000", mul_start, mul_op_a, mul_op_b);
    end
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (inflight !== 4'd1 || mul_start !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL single_t%0d got infl=%0d start=%b ov=%b want 1/0/0", k, inflight, mul_start, out_valid);
      end
      step();
    end
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_res !== 32'h40C0_0000 || inflight !== 4'd0) begin
      failures++;
      $display("[TB] FAIL single_t5 got ov=%b res=%h infl=%0d want 1/40c00000/0", out_valid, out_res, inflight);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_drain got ov=%b want 0", out_valid); end
    step();
  endtask

  task automatic test_streaming();
    int drops;
    drops = 0;
    received.delete(); expected.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_a = 32'h3F80_0000;
      in_b = 32'h3F80_0000 | (32'(i + 1) << 16);
      #1;
      if (in_ready) expected.push_back(in_b);
      else drops++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (drops != 0) begin failures++; $display("[TB] FAIL stream_in_ready_drops got=%0d want=0", drops); end
    for (int k = 0; k < 40 && received.size() < 16; k++) step();
    checks++;
    if (received.size() != 16) begin
      failures++; $display("[TB] FAIL stream_count got=%0d want=16", received.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (received[i] !== (32'h3F80_0000 | (32'(i + 1) << 16))) begin
          failures++; $display("[TB] FAIL stream_order[%0d] got=%h want=%h", i, received[i], 32'h3F80_0000 | (32'(i + 1) << 16));
        end
      end
    end
    checks++;
    if (overflow_err !== 1'b0) begin failures++; $display("[TB] FAIL stream_overflow got=%b want=0", overflow_err); end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int accepted;
    int extra_misses;
    accepted = 0; extra_misses = 0;
    received.delete(); expected.delete();
    out_ready = 1'b0;
    in_a = 32'h3F80_0000;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_b = 32'h3F80_0000 + (32'(accepted + 1) << 23);
      #1;
      if (in_ready) begin expected.push_back(in_b); accepted++; end
      step();
    end
    checks++;
    if (accepted != DEPTH) begin failures++; $display("[TB] FAIL bp_accepted got=%0d want=%0d", accepted, DEPTH); end
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_blocked got in_ready=%b want=0", in_ready); end
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_b = 32'h3F80_0000 + (32'(accepted + 1) << 23);
      #1;
      if (in_ready) begin expected.push_back(in_b); accepted++; end
      else extra_misses++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (extra_misses != 0) begin failures++; $display("[TB] FAIL bp_refill got misses=%0d want=0", extra_misses); end
    for (int k = 0; k < 40 && received.size() < 12; k++) step();
    checks++;
    if (received.size() != 12) begin
      failures++; $display("[TB] FAIL bp_count got=%0d want=12", received.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (received[i] !== (32'h3F80_0000 + (32'(i + 1) << 23))) begin
          failures++; $display("[TB] FAIL bp_order[%0d] got=%h want=%h", i, received[i], 32'h3F80_0000 + (32'(i + 1) << 23));
        end
      end
    end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_special_hazard();
    received.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4040_0000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL haz_normal_issue got=%b want=1", in_ready); end
    step();
    in_a = 32'h7FC0_0000; in_b = 32'h3F80_0000;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL haz_block_t%0d got=%b want=0", k, in_ready); end
      step();
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL haz_accept_t5 got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
    for (int k = 0; k < 20 && received.size() < 2; k++) step();
    checks++;
    if (received.size() != 2) begin
      failures++; $display("[TB] FAIL haz_count got=%0d want=2", received.size());
    end else if (received[0] !== 32'h40C0_0000 || received[1] !== 32'h7FC0_0000) begin
      failures++; $display("[TB] FAIL haz_order got=%h,%h want=40c00000,7fc00000", received[0], received[1]);
    end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_idle_zeroing();
    int bad;
    bad = 0;
    received.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4000_0000;
    step();
    in_valid = 1'b0; in_a = 32'h7F80_0000; in_b = 32'h3F80_0000;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (mul_op_a !== 32'h0 || mul_start !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL idle_zero got bad_cycles=%0d want=0", bad); end
    for (int k = 0; k < 20 && received.size() < 1; k++) step();
    checks++;
    if (received.size() != 1 || received[0] !== 32'h4080_0000) begin
      failures++;
      $display("[TB] FAIL idle_result got n=%0d res=%h want 1/40800000", received.size(),
               (received.size() > 0) ? received[0] : 32'h0);
    end
    in_a = 32'h0; in_b = 32'h0;
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000 + (32'(i) << 20);
      step();
    end
    in_valid = 1'b0;
    step();
    rst = 1'b1; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || mul_start !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_in_ready got ready=%b start=%b want 0/0", in_ready, mul_start);
    end
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || inflight !== 4'd0 || overflow_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_state got ov=%b infl=%0d err=%b want 0/0/0", out_valid, inflight, overflow_err);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("[TB] FAIL midrst_no_output got cycles=%0d want=0", seen); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_special_hazard();
    test_idle_zeroing();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
